n64_flashram_engine: RTL and testbench

Sequences the FlashRAM backing-store operations requested by the N64 FlashRAM register front end. Holds the 128-byte page buffer filled by N64 writes in buffer mode. Executes page-program and sector/chip erase commands as 16-bit write bursts on the SDRAM memory master port. Signals completion back to the front end over the SCB pending/done handshake.

---
 rtl/n64_flashram_engine.sv | 64 ++++++
 tb/tb_n64_flashram_engine.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/n64_flashram_engine.sv
// n64_flashram_engine: FlashRAM page buffer and program/erase write-burst sequencer into SDRAM
module n64_flashram_engine #(
  parameter logic [31:0] BASE_ADDRESS = 32'h03FE_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flashram_write,
  input  logic [5:0]  flashram_address,
  input  logic [15:0] flashram_wdata,
  input  logic        flashram_pending,
  input  logic        flashram_write_or_erase,
  input  logic        flashram_sector_or_all,
  input  logic [9:0]  flashram_page,
  output logic        flashram_done,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack
);
  typedef enum logic [1:0] {IDLE, WRITE, ERASE, WAIT_CLEAR} state_t;
  state_t state, state_n;
  logic [15:0] buffer [64];
  logic [15:0] start;
  logic [16:0] i, cnt, word;
  logic last;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      i <= '0;
      start <= '0;
      cnt <= '0;
      flashram_done <= 1'b0;
      for (int k = 0; k < 64; k++) buffer[k] <= 16'hFFFF;
    end else begin
      state <= state_n;
      flashram_done <= last;
      if (state == IDLE) begin
        i <= '0;
        if (flashram_write) buffer[flashram_address] <= flashram_wdata;
        if (flashram_pending) begin
          start <= !flashram_write_or_erase ? {flashram_page, 6'd0} :
                   flashram_sector_or_all ? 16'd0 : {flashram_page[9:7], 13'd0};
          cnt <= !flashram_write_or_erase ? 17'd64 :
                 flashram_sector_or_all ? 17'h10000 : 17'd8192;
        end
      end else if (mem_req && mem_ack) i <= i + 17'd1;
    end
  end
  // 17-bit counter so a 65536-word chip erase ends on the ack of word 65535
  always_comb begin
    mem_req = state == WRITE || state == ERASE;
    last = mem_req && mem_ack && (i + 17'd1 == cnt);
    word = {1'b0, start} + i;
    mem_write = mem_req;
    mem_address = mem_req ? BASE_ADDRESS + {14'd0, word, 1'b0} : 32'd0;
    mem_wdata = state == WRITE ? buffer[i[5:0]] : state == ERASE ? 16'hFFFF : 16'd0;
    busy = mem_req || flashram_done;
    state_n = state == IDLE ? (flashram_pending ? (flashram_write_or_erase ? ERASE : WRITE) : IDLE) :
              state == WAIT_CLEAR ? (flashram_pending ? WAIT_CLEAR : IDLE) :
              last ? WAIT_CLEAR : state;
  end
endmodule

// File: tb/tb_n64_flashram_engine.sv
// tb_n64_flashram_engine: directed program/erase/reset scenarios with a per-word address/data scoreboard
module tb_n64_flashram_engine;
  localparam logic [31:0] BASE = 32'h03FE_0000;
  logic clk = 1'b0, reset = 1'b0;
  logic flashram_write = 1'b0, flashram_pending = 1'b0;
  logic flashram_write_or_erase = 1'b0, flashram_sector_or_all = 1'b0;
  logic [5:0] flashram_address = '0;
  logic [15:0] flashram_wdata = '0;
  logic [9:0] flashram_page = '0;
  logic flashram_done, busy, mem_req, mem_write, mem_ack = 1'b0;
  logic [31:0] mem_address;
  logic [15:0] mem_wdata;
  int n_cmp = 0, n_bad = 0, n_done = 0;
  int exp_start = 0, exp_n = 0, exp_k = 0;
  bit exp_prog = 1'b0;
  logic [15:0] exp_buf [64];
  bit ack_hold = 1'b0, spurious = 1'b0;
  int dmin = 0, dmax = 0, wt = 0;

  n64_flashram_engine #(.BASE_ADDRESS(BASE)) dut (
    .clk(clk), .reset(reset),
    .flashram_write(flashram_write), .flashram_address(flashram_address),
    .flashram_wdata(flashram_wdata), .flashram_pending(flashram_pending),
    .flashram_write_or_erase(flashram_write_or_erase),
    .flashram_sector_or_all(flashram_sector_or_all), .flashram_page(flashram_page),
    .flashram_done(flashram_done), .busy(busy), .mem_req(mem_req), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // memory responder: ack decided just after each edge, sampled at the next one
  initial forever begin
    @(posedge clk);
    #1;
    if (ack_hold) mem_ack = 1'b1;
    else if (mem_req) begin
      if (wt == 0) begin
        mem_ack = 1'b1;
        wt = $urandom_range(dmax, dmin);
      end else begin
        mem_ack = 1'b0;
        wt--;
      end
    end else mem_ack = spurious ? 1'($urandom_range(1, 0)) : 1'b0;
  end

  // scoreboard: every cycle with mem_req must present the next expected word
  always @(negedge clk) begin
    if (flashram_done) n_done++;
    if (mem_req) begin
      chk("mem_write", 32'(mem_write), 32'd1);
      if (exp_k >= exp_n) chk("extra_word", exp_k, exp_n - 1);
      else begin
        chk("addr", mem_address, BASE + 32'(2 * (exp_start + exp_k)));
        chk("data", 32'(mem_wdata), exp_prog ? 32'(exp_buf[exp_k]) : 32'h0000FFFF);
        if (mem_ack) exp_k++;
      end
    end
  end

  task automatic run_op(input string tag, input int start, input int n, input bit prog,
                        input int budget, input bit poke);
    bit seen = 1'b0;
    exp_start = start;
    exp_n = n;
    exp_prog = prog;
    exp_k = 0;
    flashram_pending = 1'b1;
    @(negedge clk);
    flashram_write = 1'b0;
    chk({tag, "_accept_req"}, 32'(mem_req), 32'd1);
    chk({tag, "_accept_busy"}, 32'(busy), 32'd1);
    for (int c = 0; c < budget; c++) begin
      if (flashram_done) begin
        seen = 1'b1;
        break;
      end
      if (poke && c == 10) begin
        flashram_write = 1'b1;
        flashram_address = 6'd3;
        flashram_wdata = 16'hDEAD;
        flashram_page = 10'd0;
        flashram_write_or_erase = 1'b1;
        flashram_sector_or_all = 1'b1;
      end
      if (poke && c == 11) flashram_write = 1'b0;
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_done_busy"}, 32'(busy), 32'd1);
    chk({tag, "_done_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_words"}, exp_k, n);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk({tag, "_hold_done"}, 32'(flashram_done), 32'd0);
      chk({tag, "_hold_busy"}, 32'(busy), 32'd0);
      chk({tag, "_hold_req"}, 32'(mem_req), 32'd0);
    end
    flashram_pending = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 64; k++) exp_buf[k] = 16'h1000 + 16'(k);
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_write", 32'(mem_write), 32'd0);
    chk("rst_addr", mem_address, 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(flashram_done), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    for (int k = 1; k < 64; k++) begin
      flashram_write = 1'b1;
      flashram_address = 6'(k);
      flashram_wdata = 16'h1000 + 16'(k);
      @(negedge clk);
    end
    // word 0 is written on the same edge that accepts the program
    flashram_address = 6'd0;
    flashram_wdata = 16'h1000;
    flashram_page = 10'd5;
    dmin = 1;
    dmax = 1;
    wt = 1;
    run_op("prog5", 5 * 64, 64, 1'b1, 400, 1'b1);
    flashram_page = 10'd0;
    flashram_write_or_erase = 1'b0;
    flashram_sector_or_all = 1'b0;
    dmin = 0;
    dmax = 7;
    spurious = 1'b1;
    run_op("prog0_rand", 0, 64, 1'b1, 1200, 1'b0);
    spurious = 1'b0;
    ack_hold = 1'b1;
    flashram_page = 10'h3FF;
    flashram_write_or_erase = 1'b1;
    run_op("sector", 32'h0000_E000, 8192, 1'b0, 9000, 1'b0);
    flashram_page = 10'h155;
    flashram_sector_or_all = 1'b1;
    run_op("chip", 0, 65536, 1'b0, 66000, 1'b0);
    ack_hold = 1'b0;
    dmin = 0;
    dmax = 0;
    wt = 0;
    flashram_page = 10'd2;
    flashram_write_or_erase = 1'b0;
    flashram_sector_or_all = 1'b0;
    exp_start = 128;
    exp_n = 64;
    exp_prog = 1'b1;
    exp_k = 0;
    flashram_pending = 1'b1;
    begin
      bit hit = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (mem_req && mem_address == BASE + 32'(2 * (128 + 20))) begin
          hit = 1'b1;
          break;
        end
      end
      chk("abort_reached_w20", 32'(hit), 32'd1);
    end
    reset = 1'b0;
    flashram_pending = 1'b0;
    @(negedge clk);
    chk("abort_req", 32'(mem_req), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(flashram_done), 32'd0);
    chk("abort_addr", mem_address, 32'd0);
    chk("abort_wdata", 32'(mem_wdata), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 64; k++) exp_buf[k] = 16'hFFFF;
    flashram_page = 10'd1;
    run_op("after_reset", 64, 64, 1'b1, 200, 1'b0);
    chk("done_total", n_done, 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
